reg_dump_ctrl: RTL and testbench



---
 rtl/reg_dump_ctrl.sv | 132 +++++++++++++
 tb/tb_reg_dump_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl.sv
// Register dump controller: walks the processor debug port over FIRST_REG..LAST_REG
// and streams (address, data) pairs out on a valid/ready interface.
module reg_dump_ctrl #(
  parameter int FIRST_REG    = 1,
  parameter int LAST_REG     = 31,
  parameter int READ_LATENCY = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic        Abort,
  output logic        Busy,
  output logic        Done,
  output logic [4:0]  RegAddr,
  input  logic [31:0] RegData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [4:0]  OutAddr,
  output logic [31:0] OutData
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  if (!(FIRST_REG >= 0 && FIRST_REG <= LAST_REG && LAST_REG <= 31)) begin : g_bad_range
    $fatal(1, "reg_dump_ctrl: require 0 <= FIRST_REG <= LAST_REG <= 31");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $fatal(1, "reg_dump_ctrl: require READ_LATENCY >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PUSH, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [4:0]      oaddr_q, oaddr_d;
  logic [31:0]     odata_q, odata_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          addr_d  = 5'(FIRST_REG);
          cnt_d   = CW'(READ_LATENCY);
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (Abort) begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // RegData is valid on the edge where the last latency cycle ends
          if (cnt_q == CW'(1)) begin
            odata_d = RegData;
            oaddr_d = addr_q;
            valid_d = 1'b1;
            state_d = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        // Abort takes priority, so a pair offered in the abort cycle is dropped
        if (Abort) begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (OutReady) begin
          valid_d = 1'b0;
          if (addr_q == 5'(LAST_REG)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 5'd1;
            cnt_d   = CW'(READ_LATENCY);
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign RegAddr  = addr_q;
  assign OutValid = valid_q;
  assign OutAddr  = oaddr_q;
  assign OutData  = odata_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: a default instance and a single-register,
// three-cycle-latency instance.
module tb_reg_dump_ctrl;

  logic        Clock, nReset;
  logic        Start1, Abort1, Busy1, Done1, OutValid1, OutReady1;
  logic [4:0]  RegAddr1, OutAddr1;
  logic [31:0] RegData1, OutData1;
  logic        Start2, Abort2, Busy2, Done2, OutValid2, OutReady2;
  logic [4:0]  RegAddr2, OutAddr2;
  logic [31:0] RegData2, OutData2;
  logic [4:0]  pipe2 [2];

  int checks = 0;
  int errors = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  logic [36:0] q1 [$];
  logic [36:0] q2 [$];

  reg_dump_ctrl dut1 (
    .Clock(Clock), .nReset(nReset), .Start(Start1), .Abort(Abort1),
    .Busy(Busy1), .Done(Done1), .RegAddr(RegAddr1), .RegData(RegData1),
    .OutValid(OutValid1), .OutReady(OutReady1), .OutAddr(OutAddr1), .OutData(OutData1)
  );

  reg_dump_ctrl #(.FIRST_REG(5), .LAST_REG(5), .READ_LATENCY(3)) dut2 (
    .Clock(Clock), .nReset(nReset), .Start(Start2), .Abort(Abort2),
    .Busy(Busy2), .Done(Done2), .RegAddr(RegAddr2), .RegData(RegData2),
    .OutValid(OutValid2), .OutReady(OutReady2), .OutAddr(OutAddr2), .OutData(OutData2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register file models: dut1 reads combinationally, dut2 sees data two edges late
  always_comb RegData1 = 32'h1000_0000 + {27'b0, RegAddr1};
  always @(posedge Clock) begin
    pipe2[0] <= RegAddr2;
    pipe2[1] <= pipe2[0];
  end
  always_comb RegData2 = (pipe2[1] == 5'd5) ? 32'hDEAD_BEEF : 32'h2000_0000 + {27'b0, pipe2[1]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: a pair is consumed when valid&ready hold and no abort is pending
  always @(negedge Clock) begin
    if (nReset && OutValid1 && OutReady1 && !Abort1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL pair1_unexpected: actual=%0h:%0h expected=none", OutAddr1, OutData1);
      end else begin
        logic [36:0] e;
        e = q1.pop_front();
        check("pair1_addr", OutAddr1, e[36:32]);
        check("pair1_data", OutData1, e[31:0]);
      end
    end
    if (Done1) done_cnt1++;
  end

  always @(negedge Clock) begin
    if (nReset && OutValid2 && OutReady2 && !Abort2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL pair2_unexpected: actual=%0h:%0h expected=none", OutAddr2, OutData2);
      end else begin
        logic [36:0] e;
        e = q2.pop_front();
        check("pair2_addr", OutAddr2, e[36:32]);
        check("pair2_data", OutData2, e[31:0]);
      end
    end
    if (Done2) done_cnt2++;
  end

  task automatic start_dump1();
    for (int unsigned i = 1; i <= 31; i++) q1.push_back({5'(i), 32'h1000_0000 + i});
    @(posedge Clock); #1 Start1 = 1'b1;
    @(posedge Clock); #1 Start1 = 1'b0;
  endtask

  task automatic wait_done1(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge Clock); #1 n++;
      if (Done1) return;
    end
    checks++; errors++;
    $display("FAIL wait_done1_timeout: actual=no Done expected=Done within %0d", budget);
  endtask

  task automatic wait_pair1(input logic [4:0] addr, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge Clock); #1;
      if (OutValid1 && OutAddr1 == addr) return;
    end
    checks++; errors++;
    $display("FAIL wait_pair1_timeout: actual=not seen expected=pair %0d", addr);
  endtask

  initial begin
    int n, d0;
    nReset = 1'b0;
    Start1 = 1'b0; Abort1 = 1'b0; OutReady1 = 1'b1;
    Start2 = 1'b0; Abort2 = 1'b0; OutReady2 = 1'b1;
    #3;
    check("rst_busy", Busy1, 0);
    check("rst_done", Done1, 0);
    check("rst_valid", OutValid1, 0);
    check("rst_regaddr", RegAddr1, 0);
    check("rst_outaddr", OutAddr1, 0);
    check("rst_outdata", OutData1, 0);
    #9 nReset = 1'b1;

    // Full default dump, OutReady high
    d0 = done_cnt1;
    start_dump1();
    check("t1_busy", Busy1, 1);
    check("t1_regaddr_first", RegAddr1, 1);
    wait_done1(200, n);
    check("t1_cycles", n, 62);
    check("t1_busy_in_done", Busy1, 0);
    @(posedge Clock); #1;
    check("t1_done_pulse_end", Done1, 0);
    check("t1_done_count", done_cnt1 - d0, 1);
    check("t1_queue_empty", q1.size(), 0);

    // Backpressure on reg 3, Start during Busy and during DONE
    d0 = done_cnt1;
    start_dump1();
    wait_pair1(5'd3, 40);
    OutReady1 = 1'b0;
    repeat (5) begin
      @(posedge Clock); #1;
      check("t2_hold_valid", OutValid1, 1);
      check("t2_hold_addr", OutAddr1, 3);
      check("t2_hold_data", OutData1, 32'h1000_0003);
      check("t2_hold_regaddr", RegAddr1, 3);
    end
    OutReady1 = 1'b1;
    repeat (3) @(posedge Clock);
    #1 Start1 = 1'b1;
    @(posedge Clock); #1 Start1 = 1'b0;
    wait_done1(200, n);
    Start1 = 1'b1;
    @(posedge Clock); #1 Start1 = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("t6_busy_after", Busy1, 0);
    check("t6_valid_after", OutValid1, 0);
    check("t6_done_count", done_cnt1 - d0, 1);
    check("t6_queue_empty", q1.size(), 0);

    // Abort while presenting reg 10 with OutReady high
    d0 = done_cnt1;
    start_dump1();
    wait_pair1(5'd10, 40);
    Abort1 = 1'b1;
    @(posedge Clock); #1 Abort1 = 1'b0;
    check("t4_valid", OutValid1, 0);
    check("t4_busy", Busy1, 0);
    check("t4_done", Done1, 0);
    check("t4_pending_head", (q1.size() > 0) ? q1[0][36:32] : 5'd0, 10);
    q1.delete();
    repeat (3) @(posedge Clock);
    #1;
    check("t4_no_done", done_cnt1 - d0, 0);
    check("t4_idle_valid", OutValid1, 0);
    start_dump1();
    check("t4_restart_regaddr", RegAddr1, 1);
    wait_done1(200, n);
    check("t4_restart_cycles", n, 62);
    @(posedge Clock); #1;
    check("t4_queue_empty", q1.size(), 0);

    // Asynchronous reset in the middle of WAIT
    d0 = done_cnt1;
    start_dump1();
    #2 nReset = 1'b0;
    #1;
    check("t5_busy", Busy1, 0);
    check("t5_done", Done1, 0);
    check("t5_valid", OutValid1, 0);
    check("t5_regaddr", RegAddr1, 0);
    check("t5_outaddr", OutAddr1, 0);
    check("t5_outdata", OutData1, 0);
    q1.delete();
    #3 nReset = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    check("t5_idle_busy", Busy1, 0);
    check("t5_idle_regaddr", RegAddr1, 0);
    check("t5_idle_valid", OutValid1, 0);
    check("t5_no_done", done_cnt1 - d0, 0);

    // Single register, three-cycle read latency
    d0 = done_cnt2;
    q2.push_back({5'd5, 32'hDEAD_BEEF});
    @(posedge Clock); #1 Start2 = 1'b1;
    @(posedge Clock); #1 Start2 = 1'b0;
    n = 0;
    while (n < 20 && !OutValid2) begin
      @(posedge Clock); #1 n++;
    end
    check("t3_valid_delay", n, 3);
    check("t3_outaddr", OutAddr2, 5);
    check("t3_outdata", OutData2, 32'hDEAD_BEEF);
    @(posedge Clock); #1;
    check("t3_done", Done2, 1);
    check("t3_busy", Busy2, 0);
    @(posedge Clock); #1;
    check("t3_done_end", Done2, 0);
    check("t3_done_count", done_cnt2 - d0, 1);
    check("t3_queue_empty", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
